// File: rtl/opt_ctrl_pkg.sv
// rtl/opt_ctrl_pkg.sv - shared states, switch constants and counter sizing for the optical switch controller
package opt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_COLLECT,
        ST_OUTPUT,
        ST_SETTLE,
        ST_DONE,
        ST_ABORT
    } cfg_state_e;

    // 2x2 optical element settings used inside the grant words
    localparam logic P_BAR   = 1'b0;
    localparam logic P_CROSS = 1'b1;

    // Width of a counter that must hold 0..max_val without wrapping
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/opt_grant_capture.sv
// rtl/opt_grant_capture.sv - one stage's grant capture register with first-capture-wins collected flag
module opt_grant_capture #(
    parameter int P_W = 6
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clr,
    input  logic           i_cap_en,
    input  logic [P_W-1:0] i_grant,
    output logic [P_W-1:0] o_data,
    output logic           o_collected,
    output logic           o_fire
);

    // A capture only happens once per request; later valids from this stage are ignored
    assign o_fire = i_cap_en & ~o_collected;

    // Grant word and collected flag, cleared when a new request is accepted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data      <= '0;
            o_collected <= 1'b0;
        end else if (i_clr) begin
            o_data      <= '0;
            o_collected <= 1'b0;
        end else if (o_fire) begin
            o_data      <= i_grant;
            o_collected <= 1'b1;
        end
    end

endmodule

// File: rtl/optical_nxn_cfg_sequencer.sv
// rtl/optical_nxn_cfg_sequencer.sv - request broadcast, grant collection, driver handshake and settling (optional OPT_CFG_TIMEOUT_EN)
module optical_nxn_cfg_sequencer
    import opt_ctrl_pkg::*;
#(
    parameter int P_CTRL_NUM    = 4,
    parameter int P_SUB_GW      = 6,
    parameter int P_REQ_W       = 24,
    parameter int P_SETTLE_CYC  = 16,
    parameter int P_TIMEOUT_CYC = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [P_REQ_W-1:0]             i_req,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    output logic [P_REQ_W-1:0]             o_sub_req,
    output logic                           o_sub_req_valid,
    input  logic [P_CTRL_NUM*P_SUB_GW-1:0] i_sub_grant,
    input  logic [P_CTRL_NUM-1:0]          i_sub_valid,
    output logic                           o_config_end,
    output logic [P_CTRL_NUM*P_SUB_GW-1:0] o_sw_cfg,
    output logic                           o_sw_cfg_valid,
    input  logic                           i_sw_cfg_ready,
    output logic                           o_busy,
    output logic                           o_timeout,
    output logic [P_CTRL_NUM-1:0]          o_err_mask
);

    localparam int CFG_W = P_CTRL_NUM * P_SUB_GW;
    localparam int SET_W = cnt_width(P_SETTLE_CYC);

    cfg_state_e state;
    cfg_state_e state_nxt;

    logic                  accept;
    logic                  cap_window;
    logic                  all_done;
    logic                  timeout_hit;
    logic                  settle_last;
    logic [P_CTRL_NUM-1:0] collected;
    logic [P_CTRL_NUM-1:0] fire;
    logic [CFG_W-1:0]      shadow;
    logic [CFG_W-1:0]      sw_cfg_q;
    logic [SET_W-1:0]      settle_cnt;

    assign accept     = i_req_valid & o_req_ready;
    assign cap_window = (state == ST_ISSUE) || (state == ST_COLLECT);
    // Same-cycle captures count toward completion
    assign all_done   = &(collected | fire);

    for (genvar k = 0; k < P_CTRL_NUM; k++) begin : g_cap
        opt_grant_capture #(
            .P_W(P_SUB_GW)
        ) u_cap (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_clr      (accept),
            .i_cap_en   (cap_window & i_sub_valid[k]),
            .i_grant    (i_sub_grant[k*P_SUB_GW +: P_SUB_GW]),
            .o_data     (shadow[k*P_SUB_GW +: P_SUB_GW]),
            .o_collected(collected[k]),
            .o_fire     (fire[k])
        );
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (all_done) begin
                    state_nxt = ST_OUTPUT;
                end else if (timeout_hit) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_OUTPUT: begin
                if (i_sw_cfg_ready) begin
                    state_nxt = (P_SETTLE_CYC == 0) ? ST_DONE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_ABORT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Accepted request is held for the sub-controllers until the next accept
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sub_req <= '0;
        end else if (accept) begin
            o_sub_req <= i_req;
        end
    end

    // Last configuration handed to the driver; survives aborts
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sw_cfg_q <= '0;
        end else if (state == ST_OUTPUT) begin
            sw_cfg_q <= shadow;
        end
    end

    // Settling counter runs only inside SETTLE and restarts from zero on every entry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            settle_cnt <= '0;
        end else if ((state == ST_SETTLE) && !settle_last) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    assign settle_last = (int'(settle_cnt) == P_SETTLE_CYC - 1);

`ifdef OPT_CFG_TIMEOUT_EN
    localparam int TMO_W = cnt_width(P_TIMEOUT_CYC);

    logic [TMO_W-1:0]      timer;
    logic [P_CTRL_NUM-1:0] err_q;

    assign timeout_hit = (state == ST_COLLECT) && (int'(timer) == P_TIMEOUT_CYC - 1);

    // Collection timer, cleared in ISSUE and stopped at the abort point
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timer <= '0;
        end else if (state == ST_ISSUE) begin
            timer <= '0;
        end else if ((state == ST_COLLECT) && !timeout_hit) begin
            timer <= timer + 1'b1;
        end
    end

    // Missing-stage mask from the abort, held until the next request is accepted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= '0;
        end else if (accept) begin
            err_q <= '0;
        end else if (state == ST_ABORT) begin
            err_q <= ~collected;
        end
    end

    assign o_timeout  = (state == ST_ABORT);
    assign o_err_mask = (state == ST_ABORT) ? ~collected : err_q;
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
    assign o_err_mask  = '0;
`endif

    assign o_req_ready     = (state == ST_IDLE) & ~i_rst;
    assign o_busy          = (state != ST_IDLE);
    assign o_sub_req_valid = (state == ST_ISSUE);
    assign o_sw_cfg_valid  = (state == ST_OUTPUT);
    assign o_sw_cfg        = (state == ST_OUTPUT) ? shadow : sw_cfg_q;
    assign o_config_end    = (state == ST_DONE) || (state == ST_ABORT);

endmodule
